// File: rtl/itcm_arb_if.sv
//==============================================================================
// Module      : itcm_arb_if
// Description : Fetch, data and ITCM memory signals shared by itcm_arb and its
//               environment (requesters plus the memory macro).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface itcm_arb_if #(
  parameter int MEM_AW = 12
);
  // Instruction fetch port
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;

  // Data (load/store) port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  // ITCM macro port
  logic              m_en;
  logic [3:0]        m_we;
  logic [MEM_AW-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  // Environment side: requesters and the memory macro
  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

  // Arbiter side
  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/itcm_arb.sv
//==============================================================================
// Module      : itcm_arb
// Description : Shares the single ITCM port between instruction fetch and a
//               fixed-priority data port, with a starvation guard for fetch.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module itcm_arb #(
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  itcm_arb_if.slave   bus
);

  localparam logic [3:0] c_STARVE_MAX  = 4'(STARVE_MAX);
  localparam logic [1:0] c_OWNER_FETCH = 2'b01;
  localparam logic [1:0] c_OWNER_DATA  = 2'b10;

  logic [3:0]  r_starve_cnt;
  logic        r_rsp_v;
  logic [1:0]  r_rsp_owner;

  logic        w_starved;
  logic        w_f_gnt;
  logic        w_d_gnt;
  logic        w_d_rd_gnt;
  logic [31:0] w_gnt_addr;
  logic        w_unused_addr_bits;

  assign w_starved = (r_starve_cnt == c_STARVE_MAX);

  // Grants are forced low while reset is held so nothing reaches the macro.
  always_comb begin
    w_f_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (reset_n) begin
      if (w_starved && bus.f_req) begin
        w_f_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end else if (bus.f_req) begin
        w_f_gnt = 1'b1;
      end
    end
  end

  assign w_d_rd_gnt = w_d_gnt & ~bus.d_we;
  assign w_gnt_addr = w_d_gnt ? bus.d_addr : bus.f_addr;

  assign bus.f_gnt   = w_f_gnt;
  assign bus.d_gnt   = w_d_gnt;
  assign bus.m_en    = w_f_gnt | w_d_gnt;
  assign bus.m_addr  = w_gnt_addr[MEM_AW+1:2];
  assign bus.m_we    = bus.d_wstrb & {4{w_d_gnt & bus.d_we}};
  assign bus.m_wdata = bus.d_wdata;

  // Byte offset and bits above the ITCM window are deliberately ignored.
  assign w_unused_addr_bits = ^{bus.f_addr, bus.d_addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!bus.f_req || w_f_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != c_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // A response is owed only for a read granted on the previous edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_v     <= 1'b0;
      r_rsp_owner <= c_OWNER_FETCH;
    end else begin
      r_rsp_v <= w_f_gnt | w_d_rd_gnt;
      if (w_f_gnt) begin
        r_rsp_owner <= c_OWNER_FETCH;
      end else if (w_d_rd_gnt) begin
        r_rsp_owner <= c_OWNER_DATA;
      end
    end
  end

  assign bus.f_rvalid = r_rsp_v & (r_rsp_owner == c_OWNER_FETCH);
  assign bus.d_rvalid = r_rsp_v & (r_rsp_owner == c_OWNER_DATA);
  assign bus.f_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule

`default_nettype wire
